sort_sbu_cnt: RTL and testbench
===============================

// Module: sort_sbu_cnt
// PURPOSE
//  Next-generation sort bucket unit: one saturating occupancy counter per bucket instead of a single bit, so duplicate keys
//  are counted, not merged. AGU lanes increment buckets; PRU reads a bucket's count over a valid/ready handshake and
//  empties it (clear or decrement mode). Exports an occupancy bitmap so PRU can skip empty buckets.
// PARAMETERS
//  SORT_PERF_SBU_NUM    16                          number of buckets (power of 2, >=2)
//  SORT_FUC_SBU_ADDR_W  $clog2(SORT_PERF_SBU_NUM)   bucket address width (derived, do not override)
//  SORT_SBU_CNT_W       4                           counter width; max count = 2^CNT_W-1
//  SORT_SBU_WR_PORTS    2                           number of parallel AGU increment lanes (>=1)
//  SORT_SBU_CLR_ON_RD   1                           1: accepted read zeroes counter; 0: accepted read decrements by 1
// PORTS
//  clk                  in   1                      clock
//  rst                  in   1                      asynchronous reset, active-low
//  agu2sbu_vld_i        in   WR_PORTS               per-lane increment strobe
//  agu2sbu_addr_i       in   WR_PORTS*ADDR_W        per-lane bucket address, lane k at [k*ADDR_W +: ADDR_W]
//  sbu_flush_i          in   1                      synchronous clear of all counters and overflow flag
//  pru2sbu_rd_vld_i     in   1                      read request valid
//  pru2sbu_rd_addr_i    in   ADDR_W                 read bucket address
//  sbu2pru_rd_rdy_o     out  1                      read request ready
//  sbu2pru_rsp_vld_o    out  1                      response valid
//  sbu2pru_rsp_rdy_i    in   1                      response ready
//  sbu2pru_rsp_addr_o   out  ADDR_W                 address of the answered request
//  sbu2pru_rsp_cnt_o    out  CNT_W                  count returned
//  sbu2pru_occ_o        out  SORT_PERF_SBU_NUM      bit i = (counter i != 0), from registered state
//  sbu2pru_any_o        out  1                      |sbu2pru_occ_o
//  sbu_ovf_o            out  1                      sticky: some increment was lost to saturation
// BEHAVIOUR
//  - Reset (rst=0, async): all counters 0, rsp_vld_o=0, rsp_addr/cnt=0, ovf=0; hence occ=0, any=0, rd_rdy_o=1.
//  - Request accept: acc = rd_vld_i & rd_rdy_o; rd_rdy_o = ~rsp_vld_o | rsp_rdy_i (1-entry skid-free output reg).
//  - Response: registered; accepted in cycle N -> rsp_vld_o=1 in N+1 carrying addr and count as stored at end of N-1
//    (pre-update value). Held stable while rsp_vld_o & ~rsp_rdy_i. rsp_vld_o drops after handshake unless new acc.
//  - Counter update per bucket b each cycle: inc_b = number of lanes with vld & addr==b (0..WR_PORTS);
//    rd_b = acc & rd_addr==b; base = rd_b ? (CLR_ON_RD ? 0 : cnt-(cnt!=0)) : cnt;
//    next = min(base+inc_b, 2^CNT_W-1); sum computed at CNT_W+$clog2(WR_PORTS+1) bits before clamp.
//  - Saturation: if base+inc_b > max, counter = max and ovf set (sticky until flush or reset).
//  - Read of empty bucket: accepted normally, returns cnt 0, no underflow, no ovf.
//  - Same-cycle read and increment to same bucket: read returns old value; increments land after clear/decrement.
//  - Multiple lanes same bucket same cycle: all counted (inc_b>1).
//  - Flush: next cycle all counters 0, ovf 0; same-cycle increments discarded; a same-cycle acc still returns old count;
//    a pending response is unaffected. Flush has priority over every counter update.
//  - Reset mid-transaction: pending response dropped, no replay.
//  - occ/any reflect registered counters only (no same-cycle bypass).
// STRUCTURE
//  - Shared define header/package: SORT_SBU_CNT_W, SORT_SBU_WR_PORTS, SORT_SBU_CLR_ON_RD defaults next to
//    SORT_PERF_SBU_TILE_NUM / SORT_FUC_MAX_NUM; lane-count width function.
//  - Sub-module sort_sbu_cnt_cell: one bucket counter (inputs inc_b, rd_b, flush; outputs cnt, occ, sat); generated
//    SORT_PERF_SBU_NUM times. Top holds lane decode, request/response register, ovf flag.
// TESTING (NUM=16, CNT_W=4, WR_PORTS=2 unless noted)
//  1 Reset: rst low mid-traffic -> all outputs 0 immediately, rd_rdy_o=1; after release occ=0, any=0.
//  2 Dup keys: lanes 0,1 both addr 5 for 3 cycles -> cnt[5]=6, occ[5]=1; read 5 -> rsp cnt=6 next cycle, occ[5]=0 after.
//  3 Saturation: 8 cycles of both lanes to addr 3 -> cnt stays 15, ovf=1; flush -> cnt 0, ovf 0.
//  4 Collision: cnt[7]=2, same cycle read 7 + lane0 inc 7 -> rsp cnt=2; cnt[7]=1 (CLR_ON_RD=1) / 2 (CLR_ON_RD=0).
//  5 Backpressure: rsp_rdy_i=0 after accept of addr 9 -> rd_rdy_o=0, rsp held 4 cycles; rdy=1 -> next req accepted same cycle.
//  6 Empty read + decrement mode (CLR_ON_RD=0): read empty addr 0 -> cnt 0, no ovf; cnt[4]=3 read thrice -> 3,2,1, occ[4]=0.

Source files
------------

// File: rtl/sort_sbu_cnt_pkg.sv
// Shared parameters for the sort bucket unit, plus the helper that sizes the
// per-bucket increment count.
package sort_sbu_cnt_pkg;

  localparam int SORT_PERF_SBU_TILE_NUM = 4;
  localparam int SORT_PERF_SBU_NUM      = SORT_PERF_SBU_TILE_NUM * 4;
  localparam int SORT_FUC_MAX_NUM       = 1024;

  localparam int SORT_SBU_CNT_W     = 4;
  localparam int SORT_SBU_WR_PORTS  = 2;
  localparam int SORT_SBU_CLR_ON_RD = 1;

  // Bits needed to hold 0..lanes (how many lanes can hit one bucket at once).
  function automatic int sort_sbu_lane_cnt_w(input int lanes);
    return (lanes < 1) ? 1 : $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/sort_sbu_cnt_if.sv
// AGU increment lanes, PRU read request/response channel and status outputs of
// the sort bucket unit, bundled for the unit's port list.
interface sort_sbu_cnt_if
  import sort_sbu_cnt_pkg::*;
#(
  parameter int NUM      = SORT_PERF_SBU_NUM,
  parameter int CNT_W    = SORT_SBU_CNT_W,
  parameter int WR_PORTS = SORT_SBU_WR_PORTS
);
  localparam int ADDR_W = $clog2(NUM);

  logic [WR_PORTS-1:0]        agu2sbu_vld_i;
  logic [WR_PORTS*ADDR_W-1:0] agu2sbu_addr_i;
  logic                       sbu_flush_i;

  // Read request and response both use valid/ready: a transfer happens on a
  // rising clk edge where valid and ready are both high; the sender holds its
  // payload stable while valid is high and ready is low.
  logic                       pru2sbu_rd_vld_i;
  logic [ADDR_W-1:0]          pru2sbu_rd_addr_i;
  logic                       sbu2pru_rd_rdy_o;
  logic                       sbu2pru_rsp_vld_o;
  logic                       sbu2pru_rsp_rdy_i;
  logic [ADDR_W-1:0]          sbu2pru_rsp_addr_o;
  logic [CNT_W-1:0]           sbu2pru_rsp_cnt_o;

  logic [NUM-1:0]             sbu2pru_occ_o;
  logic                       sbu2pru_any_o;
  logic                       sbu_ovf_o;

  modport master (
    output agu2sbu_vld_i, agu2sbu_addr_i, sbu_flush_i,
    output pru2sbu_rd_vld_i, pru2sbu_rd_addr_i, sbu2pru_rsp_rdy_i,
    input  sbu2pru_rd_rdy_o, sbu2pru_rsp_vld_o, sbu2pru_rsp_addr_o, sbu2pru_rsp_cnt_o,
    input  sbu2pru_occ_o, sbu2pru_any_o, sbu_ovf_o
  );

  modport slave (
    input  agu2sbu_vld_i, agu2sbu_addr_i, sbu_flush_i,
    input  pru2sbu_rd_vld_i, pru2sbu_rd_addr_i, sbu2pru_rsp_rdy_i,
    output sbu2pru_rd_rdy_o, sbu2pru_rsp_vld_o, sbu2pru_rsp_addr_o, sbu2pru_rsp_cnt_o,
    output sbu2pru_occ_o, sbu2pru_any_o, sbu_ovf_o
  );

endinterface

// File: rtl/sort_sbu_cnt_cell.sv
// One bucket: saturating occupancy counter emptied by reads (clear or
// decrement) and bumped by however many AGU lanes hit it this cycle.
module sort_sbu_cnt_cell
  import sort_sbu_cnt_pkg::*;
#(
  parameter int CNT_W     = SORT_SBU_CNT_W,
  parameter int INC_W     = 2,
  parameter int CLR_ON_RD = SORT_SBU_CLR_ON_RD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_rd,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_occ,
  output logic             o_sat
);
  localparam int SUM_W = CNT_W + INC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;

  // The read takes effect before the increments, so a colliding increment survives.
  always_comb begin
    w_base = r_cnt;
    if (i_rd) begin
      if (CLR_ON_RD != 0) w_base = '0;
      else                w_base = r_cnt - CNT_W'(r_cnt != '0);
    end
    w_sum = SUM_W'(w_base) + SUM_W'(i_inc);
  end

  assign o_sat = (w_sum > CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cnt <= '0;
    else if (i_flush) r_cnt <= '0;
    else if (o_sat)   r_cnt <= '1;
    else              r_cnt <= w_sum[CNT_W-1:0];
  end

  assign o_cnt = r_cnt;
  assign o_occ = (r_cnt != '0);

endmodule

// File: rtl/sort_sbu_cnt.sv
// Sort bucket unit: per-bucket saturating counters fed by AGU lanes, read and
// emptied by the PRU through a registered single-entry response stage.
module sort_sbu_cnt
  import sort_sbu_cnt_pkg::*;
#(
  parameter int SORT_PERF_SBU_NUM  = sort_sbu_cnt_pkg::SORT_PERF_SBU_NUM,
  parameter int SORT_SBU_CNT_W     = sort_sbu_cnt_pkg::SORT_SBU_CNT_W,
  parameter int SORT_SBU_WR_PORTS  = sort_sbu_cnt_pkg::SORT_SBU_WR_PORTS,
  parameter int SORT_SBU_CLR_ON_RD = sort_sbu_cnt_pkg::SORT_SBU_CLR_ON_RD
) (
  input logic           clk,
  input logic           rst,
  sort_sbu_cnt_if.slave bus
);
  localparam int SORT_FUC_SBU_ADDR_W = $clog2(SORT_PERF_SBU_NUM);
  localparam int AW    = SORT_FUC_SBU_ADDR_W;
  localparam int CW    = SORT_SBU_CNT_W;
  localparam int INC_W = sort_sbu_lane_cnt_w(SORT_SBU_WR_PORTS);

  logic [INC_W-1:0]             w_inc [SORT_PERF_SBU_NUM];
  logic [CW-1:0]                w_cnt [SORT_PERF_SBU_NUM];
  logic [SORT_PERF_SBU_NUM-1:0] w_occ;
  logic [SORT_PERF_SBU_NUM-1:0] w_sat;
  logic [SORT_PERF_SBU_NUM-1:0] w_rd_hit;
  logic                         w_rd_rdy;
  logic                         w_acc;

  logic          r_rsp_vld;
  logic [AW-1:0] r_rsp_addr;
  logic [CW-1:0] r_rsp_cnt;
  logic          r_ovf;

  // Lane decode: per bucket, how many lanes target it this cycle.
  always_comb begin
    for (int b = 0; b < SORT_PERF_SBU_NUM; b++) begin
      w_inc[b] = '0;
      for (int k = 0; k < SORT_SBU_WR_PORTS; k++) begin
        if (bus.agu2sbu_vld_i[k] && (bus.agu2sbu_addr_i[k*AW +: AW] == AW'(b)))
          w_inc[b] = w_inc[b] + INC_W'(1);
      end
    end
  end

  assign w_rd_rdy = ~r_rsp_vld | bus.sbu2pru_rsp_rdy_i;
  assign w_acc    = bus.pru2sbu_rd_vld_i & w_rd_rdy;

  for (genvar b = 0; b < SORT_PERF_SBU_NUM; b++) begin : g_bucket
    assign w_rd_hit[b] = w_acc && (bus.pru2sbu_rd_addr_i == AW'(b));

    sort_sbu_cnt_cell #(
      .CNT_W     (CW),
      .INC_W     (INC_W),
      .CLR_ON_RD (SORT_SBU_CLR_ON_RD)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc[b]),
      .i_rd    (w_rd_hit[b]),
      .i_flush (bus.sbu_flush_i),
      .o_cnt   (w_cnt[b]),
      .o_occ   (w_occ[b]),
      .o_sat   (w_sat[b])
    );
  end

  // Response captures the pre-update count, so flush or collisions never alter it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_addr <= '0;
      r_rsp_cnt  <= '0;
    end else if (w_acc) begin
      r_rsp_vld  <= 1'b1;
      r_rsp_addr <= bus.pru2sbu_rd_addr_i;
      r_rsp_cnt  <= w_cnt[bus.pru2sbu_rd_addr_i];
    end else if (bus.sbu2pru_rsp_rdy_i) begin
      r_rsp_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_ovf <= 1'b0;
    else if (bus.sbu_flush_i) r_ovf <= 1'b0;
    else if (|w_sat)          r_ovf <= 1'b1;
  end

  assign bus.sbu2pru_rd_rdy_o   = w_rd_rdy;
  assign bus.sbu2pru_rsp_vld_o  = r_rsp_vld;
  assign bus.sbu2pru_rsp_addr_o = r_rsp_addr;
  assign bus.sbu2pru_rsp_cnt_o  = r_rsp_cnt;
  assign bus.sbu2pru_occ_o      = w_occ;
  assign bus.sbu2pru_any_o      = |w_occ;
  assign bus.sbu_ovf_o          = r_ovf;

endmodule

// File: tb/tb_sort_sbu_cnt.sv
// Bench for sort_sbu_cnt: clear-on-read instance driven from a vector table,
// random traffic and a mid-traffic reset; decrement-mode instance by hand.
module tb_sort_sbu_cnt;
  import sort_sbu_cnt_pkg::*;

  logic clk;
  logic rst;

  sort_sbu_cnt_if bus  ();
  sort_sbu_cnt_if bus2 ();

  sort_sbu_cnt u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sort_sbu_cnt #(.SORT_SBU_CLR_ON_RD(0)) u_dut_dec (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish (time %0t, limit 1000000)", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- vectors, scoreboard, model ----------------
  typedef struct {
    logic [1:0]  vld;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic        rd_vld;
    logic [3:0]  rd_addr;
    logic        rsp_rdy;
    logic        flush;
    logic        exp_rdy;
    logic [15:0] exp_occ;
    logic        exp_ovf;
  } vec_t;

  vec_t       tab[31];
  logic [7:0] exp_q[$];   // {addr, cnt} of accepted reads, oldest first
  int         m_cnt[16];
  bit         m_ovf;
  bit         m_rsp_vld;
  int         n_chk;
  int         n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] m_occ();
    logic [15:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) o[b] = (m_cnt[b] != 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 16; b++) m_cnt[b] = 0;
    m_ovf     = 1'b0;
    m_rsp_vld = 1'b0;
    exp_q.delete();
  endtask

  // Clear-on-read reference: read empties first, lane increments land after.
  task automatic model_edge(input vec_t v, input bit acc);
    int nc;
    if (acc) exp_q.push_back({v.rd_addr, 4'(m_cnt[v.rd_addr])});
    if (acc) m_rsp_vld = 1'b1;
    else if (v.rsp_rdy) m_rsp_vld = 1'b0;
    if (v.flush) begin
      for (int b = 0; b < 16; b++) m_cnt[b] = 0;
      m_ovf = 1'b0;
    end else begin
      for (int b = 0; b < 16; b++) begin
        nc = m_cnt[b];
        if (acc && int'(v.rd_addr) == b) nc = 0;
        if (v.vld[0] && int'(v.a0) == b) nc++;
        if (v.vld[1] && int'(v.a1) == b) nc++;
        if (nc > 15) begin
          nc    = 15;
          m_ovf = 1'b1;
        end
        m_cnt[b] = nc;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive1(input vec_t v);
    bus.agu2sbu_vld_i     = v.vld;
    bus.agu2sbu_addr_i    = {v.a1, v.a0};
    bus.pru2sbu_rd_vld_i  = v.rd_vld;
    bus.pru2sbu_rd_addr_i = v.rd_addr;
    bus.sbu2pru_rsp_rdy_i = v.rsp_rdy;
    bus.sbu_flush_i       = v.flush;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    return v;
  endfunction

  // One clock of the clear-on-read unit; called at posedge+1.
  task automatic step1(input vec_t v, input bit use_tab);
    bit acc;
    drive1(v);
    #1;
    acc = v.rd_vld && (!m_rsp_vld || v.rsp_rdy);
    chk("rd_rdy", 32'(bus.sbu2pru_rd_rdy_o), 32'(!m_rsp_vld || v.rsp_rdy));
    if (use_tab) chk("rd_rdy_vec", 32'(bus.sbu2pru_rd_rdy_o), 32'(v.exp_rdy));
    chk("rsp_vld", 32'(bus.sbu2pru_rsp_vld_o), 32'(m_rsp_vld));
    if (bus.sbu2pru_rsp_vld_o) begin
      chk("rsp_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        chk("rsp_addr_cnt", 32'({bus.sbu2pru_rsp_addr_o, bus.sbu2pru_rsp_cnt_o}), 32'(exp_q[0]));
        if (v.rsp_rdy) void'(exp_q.pop_front());
      end
    end
    model_edge(v, acc);
    @(posedge clk);
    #1;
    chk("occ", 32'(bus.sbu2pru_occ_o), 32'(m_occ()));
    chk("any", 32'(bus.sbu2pru_any_o), 32'(m_occ() != 16'h0));
    chk("ovf", 32'(bus.sbu_ovf_o), 32'(m_ovf));
    if (use_tab) begin
      chk("occ_vec", 32'(bus.sbu2pru_occ_o), 32'(v.exp_occ));
      chk("ovf_vec", 32'(bus.sbu_ovf_o), 32'(v.exp_ovf));
    end
  endtask

  task automatic step2(input logic [1:0] vld, input logic [3:0] a0, input logic [3:0] a1,
                       input logic rd_vld, input logic [3:0] rd_addr);
    bus2.agu2sbu_vld_i     = vld;
    bus2.agu2sbu_addr_i    = {a1, a0};
    bus2.pru2sbu_rd_vld_i  = rd_vld;
    bus2.pru2sbu_rd_addr_i = rd_addr;
    bus2.sbu2pru_rsp_rdy_i = 1'b1;
    bus2.sbu_flush_i       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    n_chk  = 0;
    n_pass = 0;
    model_reset();

    // vld, a0, a1, rd_vld, rd_addr, rsp_rdy, flush, exp_rdy, exp_occ, exp_ovf
    for (int i = 0; i < 3; i++) tab[i] = '{2'b11, 4'd5, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b0};
    tab[3]  = '{2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    tab[4]  = idle_vec();
    for (int i = 5; i < 12; i++) tab[i] = '{2'b11, 4'd3, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b0};
    tab[12] = '{2'b11, 4'd3, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1};
    tab[13] = '{2'b11, 4'd3, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1};
    tab[14] = '{2'b11, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
    tab[15] = '{2'b01, 4'd7, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0};
    tab[16] = '{2'b01, 4'd7, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0};
    tab[17] = '{2'b01, 4'd7, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0};
    tab[18] = '{2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0};
    tab[19] = '{2'b11, 4'd9, 4'd7, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0280, 1'b0};
    tab[20] = '{2'b00, 4'd0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b0};
    for (int i = 21; i < 25; i++) tab[i] = '{2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0};
    tab[25] = '{2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    tab[26] = idle_vec();
    tab[27] = '{2'b11, 4'd0, 4'd15, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h8001, 1'b0};
    tab[28] = '{2'b10, 4'd0, 4'd15, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0};
    tab[29] = '{2'b00, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    tab[30] = idle_vec();

    rst = 1'b0;
    drive1(idle_vec());
    step2(2'b00, 4'd0, 4'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_vld", 32'(bus.sbu2pru_rsp_vld_o), 32'(0));
    chk("reset_rsp_addr", 32'(bus.sbu2pru_rsp_addr_o), 32'(0));
    chk("reset_rsp_cnt", 32'(bus.sbu2pru_rsp_cnt_o), 32'(0));
    chk("reset_occ", 32'(bus.sbu2pru_occ_o), 32'(0));
    chk("reset_any", 32'(bus.sbu2pru_any_o), 32'(0));
    chk("reset_ovf", 32'(bus.sbu_ovf_o), 32'(0));
    chk("reset_rd_rdy", 32'(bus.sbu2pru_rd_rdy_o), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 31; i++) step1(tab[i], 1'b1);

    // Random traffic; odd cycles crowd four buckets to provoke saturation.
    for (int i = 0; i < 300; i++) begin
      v.vld     = 2'($urandom_range(0, 3));
      v.a0      = 4'($urandom_range(0, (i % 2 == 1) ? 3 : 15));
      v.a1      = 4'($urandom_range(0, (i % 2 == 1) ? 3 : 15));
      v.rd_vld  = 1'($urandom_range(0, 1));
      v.rd_addr = 4'($urandom_range(0, (i % 4 == 0) ? 3 : 15));
      v.rsp_rdy = ($urandom_range(0, 3) != 0);
      v.flush   = ($urandom_range(0, 40) == 0);
      v.exp_rdy = 1'b0;
      v.exp_occ = '0;
      v.exp_ovf = 1'b0;
      step1(v, 1'b0);
    end

    // Reset with a response pending and counters occupied.
    v = '{2'b11, 4'd2, 4'd2, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    step1(v, 1'b0);
    drive1(v);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rsp_vld", 32'(bus.sbu2pru_rsp_vld_o), 32'(0));
    chk("midrst_rsp_addr", 32'(bus.sbu2pru_rsp_addr_o), 32'(0));
    chk("midrst_rsp_cnt", 32'(bus.sbu2pru_rsp_cnt_o), 32'(0));
    chk("midrst_occ", 32'(bus.sbu2pru_occ_o), 32'(0));
    chk("midrst_any", 32'(bus.sbu2pru_any_o), 32'(0));
    chk("midrst_ovf", 32'(bus.sbu_ovf_o), 32'(0));
    chk("midrst_rd_rdy", 32'(bus.sbu2pru_rd_rdy_o), 32'(1));
    model_reset();
    drive1(idle_vec());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_occ", 32'(bus.sbu2pru_occ_o), 32'(0));
    chk("postrst_any", 32'(bus.sbu2pru_any_o), 32'(0));
    chk("postrst_rsp_vld", 32'(bus.sbu2pru_rsp_vld_o), 32'(0));

    step1('{2'b01, 4'd6, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}, 1'b0);
    step1('{2'b00, 4'd0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}, 1'b0);
    step1(idle_vec(), 1'b0);
    step1(idle_vec(), 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    // Decrement-mode unit: empty read, 3-2-1 drain, read/increment collision.
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd0);
    chk("dec_empty_vld", 32'(bus2.sbu2pru_rsp_vld_o), 32'(1));
    chk("dec_empty_addr", 32'(bus2.sbu2pru_rsp_addr_o), 32'(0));
    chk("dec_empty_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(0));
    chk("dec_empty_ovf", 32'(bus2.sbu_ovf_o), 32'(0));
    chk("dec_empty_occ", 32'(bus2.sbu2pru_occ_o), 32'(0));
    step2(2'b11, 4'd4, 4'd4, 1'b0, 4'd0);
    step2(2'b01, 4'd4, 4'd0, 1'b0, 4'd0);
    chk("dec_fill_occ", 32'(bus2.sbu2pru_occ_o), 32'(16'h0010));
    chk("dec_fill_vld_drop", 32'(bus2.sbu2pru_rsp_vld_o), 32'(0));
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd4);
    chk("dec_rd1_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(3));
    chk("dec_rd1_addr", 32'(bus2.sbu2pru_rsp_addr_o), 32'(4));
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd4);
    chk("dec_rd2_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(2));
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd4);
    chk("dec_rd3_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(1));
    chk("dec_rd3_occ", 32'(bus2.sbu2pru_occ_o), 32'(0));
    step2(2'b11, 4'd7, 4'd7, 1'b0, 4'd0);
    step2(2'b01, 4'd7, 4'd0, 1'b1, 4'd7);
    chk("dec_coll_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(2));
    chk("dec_coll_occ", 32'(bus2.sbu2pru_occ_o), 32'(16'h0080));
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd7);
    chk("dec_after_coll_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(2));
    step2(2'b00, 4'd0, 4'd0, 1'b1, 4'd7);
    chk("dec_last_cnt", 32'(bus2.sbu2pru_rsp_cnt_o), 32'(1));
    chk("dec_last_occ", 32'(bus2.sbu2pru_occ_o), 32'(0));
    chk("dec_last_any", 32'(bus2.sbu2pru_any_o), 32'(0));
    chk("dec_ovf", 32'(bus2.sbu_ovf_o), 32'(0));
    step2(2'b00, 4'd0, 4'd0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
